// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, mid-bit sampling.
// Raw rx pin in; framed byte plus one-cycle done / frame-error strobes out.
module uart_rx #(
    parameter int BAUD_DIV = 54,
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_done,
    output logic            frame_err,
    output logic            busy
);

    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(BAUD_DIV - 1);
    localparam logic [NW-1:0] NMAX = NW'(DBIT - 1);
    localparam logic [3:0] SMID = 4'd7;
    localparam logic [3:0] SBIT = 4'd15;
    localparam logic [3:0] SSTP = 4'(SB_TICK - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    logic          rx_meta_q;
    logic          rx_s_q;
    logic          rx_prev_q;
    logic [TW-1:0] tcnt_q;
    logic          tick;

    state_e          state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;

    assign tick = (tcnt_q == TMAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            tcnt_q    <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            tcnt_q    <= tick ? '0 : tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == SMID) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == SBIT) begin
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        s_d = '0;
                        if (n_q == NMAX) state_d = STOP;
                        else n_d = n_q + 1'b1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                // Stay in STOP while the strobe is high so busy drops one clk later.
                if (done_q || ferr_q) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (s_q == SSTP) begin
                        if (rx_s_q) begin
                            done_d = 1'b1;
                            data_d = b_q;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized checks of uart_rx at BAUD_DIV=4 (one bit = 64 clk).
// A byte-level queue model predicts what the receiver must deliver.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_NS = 640;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    int passed = 0;
    int total  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         viol     = 0;
    logic [7:0] ferr_data;
    logic       busy_at_done;
    logic       busy_after;
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] prev_data;

    uart_rx #(.BAUD_DIV(4), .DBIT(8), .SB_TICK(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Observe on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (rx_done) begin
                done_cnt++;
                got_q.push_back(rx_data);
                busy_at_done = busy;
            end
            if (prev_done) busy_after = busy;
            if (frame_err) begin
                ferr_cnt++;
                ferr_data = rx_data;
            end
            if (rx_done && frame_err) viol++;
            if ((prev_done || prev_ferr) && (rx_done || frame_err)) viol++;
            if (rx_data !== prev_data && !rx_done) viol++;
        end
        prev_done = rx_done;
        prev_ferr = frame_err;
        prev_data = rx_data;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_frame(input logic [7:0] d, input int bit_ns,
                              input logic stop);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bit_ns);
        end
        rx = stop;
        #(bit_ns);
    endtask

    task automatic send_good(input logic [7:0] d, input int bit_ns);
        exp_q.push_back(d);
        send_frame(d, bit_ns, 1'b1);
    endtask

    task automatic check_queue(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] g;
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            check({tag, "_byte"}, {24'd0, g}, {24'd0, exp_q[i]});
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        int         d0, f0, bit_ns, idle_ns;
        logic [7:0] d;

        #3 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_data", {24'd0, rx_data}, 32'h0);
        check("rst_done", {31'd0, rx_done}, 32'h0);
        check("rst_ferr", {31'd0, frame_err}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        rst = 1'b1;
        #(2 * BIT_NS);

        // Single frame
        send_good(8'hA5, BIT_NS);
        #(2 * BIT_NS);
        check_queue("a5");
        check("a5_data", {24'd0, rx_data}, 32'hA5);
        check("a5_ferr", 32'(ferr_cnt), 32'd0);
        check("a5_busy_at_done", {31'd0, busy_at_done}, 32'h1);
        check("a5_busy_after", {31'd0, busy_after}, 32'h0);

        // Back-to-back, zero idle
        send_good(8'h00, BIT_NS);
        send_good(8'hFF, BIT_NS);
        send_good(8'h3C, BIT_NS);
        #(2 * BIT_NS);
        check_queue("b2b");

        // Short glitch on idle line
        d0 = done_cnt;
        rx = 1'b0;
        #120;
        rx = 1'b1;
        #(2 * BIT_NS);
        @(negedge clk);
        check("glitch_done", 32'(done_cnt), 32'(d0));
        check("glitch_ferr", 32'(ferr_cnt), 32'd0);
        check("glitch_busy", {31'd0, busy}, 32'h0);
        check("glitch_data", {24'd0, rx_data}, 32'h3C);

        // Framing error then long break
        send_good(8'h5A, BIT_NS);
        send_frame(8'h81, BIT_NS, 1'b0);
        @(negedge clk);
        check("ferr_cnt", 32'(ferr_cnt), 32'd1);
        check("ferr_data", {24'd0, ferr_data}, 32'h5A);
        check("ferr_hold", {24'd0, rx_data}, 32'h5A);
        d0 = done_cnt;
        f0 = ferr_cnt;
        #(30 * BIT_NS);
        check("break_done", 32'(done_cnt), 32'(d0));
        check("break_ferr", 32'(ferr_cnt), 32'(f0));
        check("break_busy", {31'd0, busy}, 32'h0);
        rx = 1'b1;
        #(2 * BIT_NS);
        send_good(8'h11, BIT_NS);
        #(2 * BIT_NS);
        check_queue("after_break");
        check("after_break_data", {24'd0, rx_data}, 32'h11);

        // Reset during data bit 4
        d0 = done_cnt;
        d  = 8'hC3;
        @(negedge clk);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            #(BIT_NS);
        end
        rx = d[4];
        #(BIT_NS / 2);
        check("mid_busy_pre", {31'd0, busy}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_data", {24'd0, rx_data}, 32'h0);
        check("arst_done", {31'd0, rx_done}, 32'h0);
        check("arst_ferr", {31'd0, frame_err}, 32'h0);
        check("arst_busy", {31'd0, busy}, 32'h0);
        rx = 1'b1;
        #(2 * BIT_NS);
        @(negedge clk);
        rst = 1'b1;
        #(2 * BIT_NS);
        check("arst_no_pulse", 32'(done_cnt), 32'(d0));
        send_good(8'h7E, BIT_NS);
        #(2 * BIT_NS);
        check_queue("post_rst");
        check("post_rst_data", {24'd0, rx_data}, 32'h7E);

        // Random bytes with up to +/-2% baud skew
        f0 = ferr_cnt;
        for (int k = 0; k < 80; k++) begin
            d       = 8'($urandom);
            bit_ns  = 627 + $urandom_range(0, 26);
            idle_ns = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 300) : 0;
            send_good(d, bit_ns);
            if (idle_ns > 0) #(idle_ns);
        end
        #(2 * BIT_NS);
        check_queue("sweep");
        check("sweep_ferr", 32'(ferr_cnt), 32'(f0));
        check("invariants", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
